// File: rtl/noc_pkg.sv
// Shared NoC link types and constants used by the router input stage and the
// upstream VC multiplexer / credit counter.
package noc_pkg;

  localparam int DATAW  = 8;
  localparam int VCHW   = 2;
  localparam int VCH    = 2;
  localparam int PORT_W = 3;
  localparam logic ENABLE = 1'b1;

  localparam int VC_NUM = 2;

  typedef logic [VC_NUM-1:0] credit_t;

  typedef struct packed {
    logic             valid;
    logic [VCHW-1:0]  vch;
    logic [DATAW-1:0] data;
  } router_i_t;

  // Payload actually held in a VC FIFO entry (valid is implied by occupancy).
  typedef struct packed {
    logic [VCHW-1:0]  vch;
    logic [DATAW-1:0] data;
  } flit_t;

  function automatic logic vch_legal(input logic [VCHW-1:0] vch);
    return vch < VCHW'(VC_NUM);
  endfunction

endpackage

// File: rtl/vcdemux_buf_vc_fifo.sv
// Single-VC input FIFO: registered storage, no write-to-read bypass, head
// zeroed when empty so several heads can be OR-combined downstream.
module vc_fifo
  import noc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  flit_t     push_data,
  input  logic      pop,
  output router_i_t head,
  output logic      empty,
  output logic      full
);

  localparam int PTR_W = $clog2(DEPTH);

  flit_t            mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_W'(DEPTH));

  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  always_comb begin
    head = '0;
    if (!empty) begin
      head.valid = 1'b1;
      head.vch   = mem_q[rd_ptr_q].vch;
      head.data  = mem_q[rd_ptr_q].data;
    end
  end

endmodule

// File: rtl/vcdemux_buf.sv
// Router input port: demultiplexes the two-VC link into per-VC FIFOs and
// returns one credit per consumed flit to the upstream sender.
module vcdemux_buf
  import noc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  router_i_t              link_i,
  output router_i_t [VC_NUM-1:0] vc_flit_o,
  input  credit_t                vc_pop_i,
  output credit_t                credit_o,
  output credit_t                full_o,
  output logic                   err_ovf_o
);

  credit_t push_v, pop_ok, empty_v, full_v, ovf_v;
  credit_t credit_q, credit_d;
  logic    err_q, err_d;
  logic    vch_ok;
  flit_t   link_flit;

  assign vch_ok    = vch_legal(link_i.vch);
  assign link_flit = '{vch: link_i.vch, data: link_i.data};

  for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
    assign push_v[v] = link_i.valid && vch_ok && (link_i.vch == VCHW'(v));
    assign pop_ok[v] = vc_pop_i[v] && !empty_v[v];
    // Full with a same-cycle pop is not an overflow: the pop frees the slot.
    assign ovf_v[v]  = push_v[v] && full_v[v] && !vc_pop_i[v];

    vc_fifo #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_v[v]),
      .push_data (link_flit),
      .pop       (vc_pop_i[v]),
      .head      (vc_flit_o[v]),
      .empty     (empty_v[v]),
      .full      (full_v[v])
    );
  end

  always_comb begin
    credit_d = pop_ok;
    err_d    = err_q || (|ovf_v) || (link_i.valid && !vch_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credit_q <= '0;
      err_q    <= 1'b0;
    end else begin
      credit_q <= credit_d;
      err_q    <= err_d;
    end
  end

  assign credit_o  = credit_q;
  assign full_o    = full_v;
  assign err_ovf_o = err_q;

endmodule

// File: tb/tb_vcdemux_buf.sv
// Table-driven bench for vcdemux_buf with per-VC scoreboard queues of flit data.
module tb_vcdemux_buf;
  import noc_pkg::*;

  localparam int DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  router_i_t              link_i = '0;
  router_i_t [VC_NUM-1:0] vc_flit_o;
  credit_t                vc_pop_i = '0;
  credit_t                credit_o;
  credit_t                full_o;
  logic                   err_ovf_o;

  vcdemux_buf #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .link_i    (link_i),
    .vc_flit_o (vc_flit_o),
    .vc_pop_i  (vc_pop_i),
    .credit_o  (credit_o),
    .full_o    (full_o),
    .err_ovf_o (err_ovf_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       lv;
    logic [7:0] data;
    logic [1:0] vch;
    logic [1:0] pop;
    logic [1:0] ev;
    logic [1:0] ef;
    logic [1:0] ec;
    logic       ee;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] sbq0[$];
  logic [7:0] sbq1[$];
  int         ncmp = 0;
  int         miss = 0;

  function automatic vec_t mk(input logic r, input logic lv, input logic [7:0] d,
                              input logic [1:0] vch, input logic [1:0] pop,
                              input logic [1:0] ev, input logic [1:0] ef,
                              input logic [1:0] ec, input logic ee);
    vec_t t;
    t.rst = r; t.lv = lv; t.data = d; t.vch = vch; t.pop = pop;
    t.ev = ev; t.ef = ef; t.ec = ec; t.ee = ee;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input vec_t t);
    int   qs [2];
    logic popd [2];
    logic acc;
    @(negedge clk);
    rst            = t.rst;
    link_i.valid   = t.lv;
    link_i.data    = t.data;
    link_i.vch     = t.vch;
    vc_pop_i       = t.pop;
    #1;
    qs[0] = sbq0.size();
    qs[1] = sbq1.size();
    for (int v = 0; v < 2; v++) begin
      popd[v] = !t.rst && t.pop[v] && (qs[v] > 0);
      if (popd[v])
        chk($sformatf("head%0d", v),
            {20'd0, vc_flit_o[v].valid, vc_flit_o[v].vch, vc_flit_o[v].data},
            {20'd0, 1'b1, 2'(v), (v == 0) ? sbq0[0] : sbq1[0]});
    end
    acc = !t.rst && t.lv && (t.vch < 2) &&
          ((qs[t.vch[0]] < DEPTH) || popd[t.vch[0]]);
    @(posedge clk);
    #1;
    if (t.rst) begin
      sbq0.delete();
      sbq1.delete();
    end else begin
      if (popd[0]) void'(sbq0.pop_front());
      if (popd[1]) void'(sbq1.pop_front());
      if (acc) begin
        if (t.vch == 2'd0) sbq0.push_back(t.data);
        else               sbq1.push_back(t.data);
      end
    end
    chk("valid",  {30'd0, vc_flit_o[1].valid, vc_flit_o[0].valid}, {30'd0, t.ev});
    chk("full",   {30'd0, full_o},   {30'd0, t.ef});
    chk("credit", {30'd0, credit_o}, {30'd0, t.ec});
    chk("err",    {31'd0, err_ovf_o}, {31'd0, t.ee});
    for (int v = 0; v < 2; v++)
      if (!t.ev[v])
        chk($sformatf("empty_head%0d", v),
            {22'd0, vc_flit_o[v].vch, vc_flit_o[v].data}, 32'd0);
  endtask

  initial begin
    // Reset then idle
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 0));
    // Single flit through VC0 and its credit
    tbl.push_back(mk(0, 1, 8'hA1, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 0));
    // Fill VC1, overflow, drain
    for (int d = 1; d <= 4; d++)
      tbl.push_back(mk(0, 1, 8'(d), 1, 0, 2, (d == 4) ? 2'd2 : 2'd0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h05, 1, 0, 2, 2, 0, 1));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 0, 8'h00, 0, 2, 2, 0, 2, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 2, 0, 0, 2, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 1));
    // Full VC1 with simultaneous push and pop
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 0, 0));
    for (int d = 1; d <= 4; d++)
      tbl.push_back(mk(0, 1, 8'(d), 1, 0, 2, (d == 4) ? 2'd2 : 2'd0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h09, 1, 2, 2, 2, 2, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 2, 2, 0, 0));
    // Push VC0 while popping VC1
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 1, 8'(8'h10 + i), 0, 2, 3, 0, 2, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 3, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 3, 1, 0, 3, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 2, 1, 0, 0, 0));
    // Reset during a pop with VC0 holding three flits
    tbl.push_back(mk(0, 1, 8'h13, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'h00, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // Illegal VC numbers are dropped and flag the error
    step(mk(0, 1, 8'h55, 2, 0, 0, 0, 0, 1));
    step(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 1));
    step(mk(0, 1, 8'h77, 3, 0, 0, 0, 0, 1));
    step(mk(0, 1, 8'h66, 0, 0, 1, 0, 0, 1));
    step(mk(0, 0, 8'h00, 0, 1, 0, 0, 1, 1));
    step(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 1));

    $display("== %0d vectors applied, %0d miscompares ==", ncmp, miss);
    $finish;
  end

endmodule
